// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the single-cycle MIPS core.
//   * XLEN / register-file geometry
//   * opcode and R-type funct encodings
//   * ALU operation enum and the ALU evaluation function
// Optional feature macro used elsewhere in the slice: MIPS_BNE_EN
// (enables the bne instruction in mips_cpu).
package mips_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  // Primary opcodes (IM_DATA[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IM_DATA[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  // Pure 32-bit wraparound ALU; there is no overflow detection at all.
  function automatic logic [XLEN-1:0] alu_exec(input alu_op_e op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// mips_regfile -- 32 x 32-bit register file.
// Ports:
//   clk_i                 clock, writes and reset on rising edge
//   rst_i                 synchronous active-high clear of all registers
//   we_i, waddr_i, wdata_i  single synchronous write port
//   raddr_a_i / rdata_a_o   combinational read port A (rs)
//   raddr_b_i / rdata_b_o   combinational read port B (rt)
// Register $0 reads as zero and ignores writes. Reads return the value held
// before the current edge, so an instruction reading and writing the same
// register sees the old value.
module mips_regfile
  import mips_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  output logic [XLEN-1:0]   rdata_a_o,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [XLEN-1:0]   rdata_b_o
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/mips_cpu.sv
// mips_cpu -- single-cycle MIPS subset core (CPI 1).
// Supported: add, sub, and, or, slt, addi, lw, sw, beq, j
//            (+ bne when MIPS_BNE_EN is defined at compile time).
// Anything else advances PC by 4 with no register or memory side effect.
// Parameter:
//   RESET_PC    PC value loaded while Z_R is high
// Ports:
//   CLK         single clock for core and both memories
//   Z_R         synchronous active-high reset
//   IM_ADDR     instruction fetch byte address (= PC)
//   IM_DATA     instruction word at IM_ADDR
//   DM_WE       data-memory write enable (stores only)
//   DM_ADDR     data-memory byte address (= ALU result)
//   DM_WR_DATA  store data (= register rt)
//   DM_RD_DATA  load data for DM_ADDR
module mips_cpu
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Z_R,
  output logic [31:0] IM_ADDR,
  input  logic [31:0] IM_DATA,
  output logic        DM_WE,
  output logic [31:0] DM_ADDR,
  output logic [31:0] DM_WR_DATA,
  input  logic [31:0] DM_RD_DATA
);

  // Instruction fields
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [15:0]       imm16;
  logic [25:0]       imm26;
  logic [XLEN-1:0]   imm_sext;

  assign opcode   = IM_DATA[31:26];
  assign rs       = IM_DATA[25:21];
  assign rt       = IM_DATA[20:16];
  assign rd       = IM_DATA[15:11];
  assign funct    = IM_DATA[5:0];
  assign imm16    = IM_DATA[15:0];
  assign imm26    = IM_DATA[25:0];
  assign imm_sext = {{16{imm16[15]}}, imm16};

  // Decoded control
  logic    reg_we;
  logic    wr_sel_rd;
  logic    alu_src_imm;
  logic    mem_we;
  logic    mem_to_reg;
  logic    branch_eq;
  logic    branch_ne;
  logic    jump;
  alu_op_e alu_op;

  always_comb begin
    reg_we      = 1'b0;
    wr_sel_rd   = 1'b0;
    alu_src_imm = 1'b0;
    mem_we      = 1'b0;
    mem_to_reg  = 1'b0;
    branch_eq   = 1'b0;
    branch_ne   = 1'b0;
    jump        = 1'b0;
    alu_op      = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin reg_we = 1'b1; wr_sel_rd = 1'b1; alu_op = ALU_ADD; end
          FN_SUB: begin reg_we = 1'b1; wr_sel_rd = 1'b1; alu_op = ALU_SUB; end
          FN_AND: begin reg_we = 1'b1; wr_sel_rd = 1'b1; alu_op = ALU_AND; end
          FN_OR:  begin reg_we = 1'b1; wr_sel_rd = 1'b1; alu_op = ALU_OR;  end
          FN_SLT: begin reg_we = 1'b1; wr_sel_rd = 1'b1; alu_op = ALU_SLT; end
          default: ;
        endcase
      end
      OP_ADDI: begin
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
      end
      OP_LW: begin
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        mem_to_reg  = 1'b1;
      end
      OP_SW: begin
        alu_src_imm = 1'b1;
        mem_we      = 1'b1;
      end
      OP_BEQ: branch_eq = 1'b1;
`ifdef MIPS_BNE_EN
      OP_BNE: branch_ne = 1'b1;
`endif
      OP_J:   jump = 1'b1;
      default: ;
    endcase
  end

  // Register file
  logic [XLEN-1:0]   rs_val, rt_val;
  logic [XLEN-1:0]   wb_data;
  logic [REG_AW-1:0] wb_addr;
  logic              wb_en;

  // Reset suppresses the write so an abandoned instruction leaves no trace.
  assign wb_en   = reg_we & ~Z_R;
  assign wb_addr = wr_sel_rd ? rd : rt;

  mips_regfile u_regfile (
    .clk_i     (CLK),
    .rst_i     (Z_R),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (rs),
    .rdata_a_o (rs_val),
    .raddr_b_i (rt),
    .rdata_b_o (rt_val)
  );

  // Execute
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_res;

  assign alu_b   = alu_src_imm ? imm_sext : rt_val;
  assign alu_res = alu_exec(alu_op, rs_val, alu_b);
  assign wb_data = mem_to_reg ? DM_RD_DATA : alu_res;

  // Data memory interface; the write enable is a pure AND of decoded bits,
  // so it settles once IM_DATA is stable and is forced low during reset.
  assign DM_WE      = mem_we & ~Z_R;
  assign DM_ADDR    = alu_res;
  assign DM_WR_DATA = rt_val;

  // Next PC
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] br_target;
  logic            regs_equal;
  logic            take_branch;

  assign pc_plus4    = pc_q + 32'd4;          // wraps modulo 2^32
  assign br_off      = imm_sext << 2;
  assign br_target   = pc_plus4 + br_off;
  assign regs_equal  = (rs_val == rt_val);
  assign take_branch = (branch_eq & regs_equal) | (branch_ne & ~regs_equal);

  always_comb begin
    pc_d = pc_plus4;
    if (jump) begin
      pc_d = {pc_plus4[31:28], imm26, 2'b00};
    end else if (take_branch) begin
      pc_d = br_target;
    end
  end

  always_ff @(posedge CLK) begin
    if (Z_R) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign IM_ADDR = pc_q;

endmodule

// File: tb/tb_mips_cpu.sv
// tb_mips_cpu -- self-checking bench for mips_cpu.
// The bench models instruction and data memory, loads small programs, and
// observes register contents through stores. Expected stores (addr, data)
// and expected PC values are queued when a program is set up and compared
// as the core produces them.
module tb_mips_cpu;

  logic        CLK;
  logic        Z_R;
  logic [31:0] IM_ADDR;
  logic [31:0] IM_DATA;
  logic        DM_WE;
  logic [31:0] DM_ADDR;
  logic [31:0] DM_WR_DATA;
  logic [31:0] DM_RD_DATA;

  mips_cpu #(.RESET_PC(32'h0000_0000)) dut (
    .CLK        (CLK),
    .Z_R        (Z_R),
    .IM_ADDR    (IM_ADDR),
    .IM_DATA    (IM_DATA),
    .DM_WE      (DM_WE),
    .DM_ADDR    (DM_ADDR),
    .DM_WR_DATA (DM_WR_DATA),
    .DM_RD_DATA (DM_RD_DATA)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memories
  logic [31:0] imem [128];
  logic [31:0] dmem [64];
  int          pa;

  assign IM_DATA    = imem[IM_ADDR[8:2]];
  assign DM_RD_DATA = dmem[DM_ADDR[7:2]];

  always @(posedge CLK) begin
    if (DM_WE) dmem[DM_ADDR[7:2]] <= DM_WR_DATA;
  end

  // Scoreboard
  logic [63:0] exp_q [$];
  logic [31:0] pc_q  [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Encoders
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  // Driver tasks
  task automatic clear_mem();
    for (int i = 0; i < 128; i++) imem[i] = 32'h0;
    for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
    pa = 0;
    exp_q.delete();
    pc_q.delete();
  endtask

  task automatic emit(input logic [31:0] instr);
    imem[pa] = instr;
    pa++;
  endtask

  task automatic exp_store(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  // Holds Z_R for two rising edges, checks reset outputs, returns at a
  // falling edge with Z_R low so the next cycle fetches from RESET_PC.
  task automatic do_reset();
    Z_R = 1'b1;
    repeat (2) begin
      @(posedge CLK);
      @(negedge CLK);
      check_eq("rst_we", {31'b0, DM_WE}, 32'd0);
      check_eq("rst_pc", IM_ADDR, 32'h0);
    end
    Z_R = 1'b0;
  endtask

  // Samples the current cycle, then advances to the next falling edge.
  task automatic step();
    logic [63:0] e;
    #1;
    if (pc_q.size() > 0) check_eq("pc", IM_ADDR, pc_q.pop_front());
    if (exp_q.size() == 0) begin
      check_eq("idle_we", {31'b0, DM_WE}, 32'd0);
    end else if (DM_WE) begin
      e = exp_q.pop_front();
      check_eq("st_addr", DM_ADDR, e[63:32]);
      check_eq("st_data", DM_WR_DATA, e[31:0]);
    end
    @(negedge CLK);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic end_test();
    check_eq("pending", exp_q.size(), 32'd0);
    exp_q.delete();
    pc_q.delete();
  endtask

  initial begin
    Z_R = 1'b1;
    clear_mem();
    @(negedge CLK);

    // Reset: a store at RESET_PC must not fire while Z_R is high.
    clear_mem();
    emit(enc_i(6'h2B, 5'd0, 5'd0, 16'h0));       // 0x0 sw $0,0($0)
    emit(enc_j(26'd1));                          // 0x4 j 0x4
    do_reset();
    pc_q.push_back(32'h0);
    pc_q.push_back(32'h4);
    pc_q.push_back(32'h4);
    exp_store(32'h0, 32'h0);
    run(3);
    end_test();

    // Arithmetic, unsupported encodings, read-old-value on same register
    clear_mem();
    emit(enc_i(6'h08, 5'd0, 5'd1, 16'd5));        // addi $1,$0,5
    emit(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));     // addi $2,$0,-3
    emit(enc_r(5'd1, 5'd2, 5'd3, 6'h20));         // add  $3,$1,$2
    emit(enc_r(5'd2, 5'd1, 5'd4, 6'h2A));         // slt  $4,$2,$1
    emit(enc_r(5'd2, 5'd1, 5'd5, 6'h22));         // sub  $5,$2,$1
    emit(enc_r(5'd1, 5'd2, 5'd6, 6'h24));         // and  $6,$1,$2
    emit(enc_r(5'd1, 5'd2, 5'd7, 6'h25));         // or   $7,$1,$2
    emit(enc_r(5'd1, 5'd2, 5'd8, 6'h2A));         // slt  $8,$1,$2
    emit(enc_i(6'h08, 5'd1, 5'd1, 16'd1));        // addi $1,$1,1
    emit(enc_i(6'h0C, 5'd0, 5'd3, 16'h7));        // andi (unsupported) -> $3
    emit(enc_r(5'd1, 5'd2, 5'd3, 6'h26));         // xor  (unsupported) -> $3
    emit(enc_i(6'h2B, 5'd0, 5'd3, 16'h20));
    emit(enc_i(6'h2B, 5'd0, 5'd4, 16'h24));
    emit(enc_i(6'h2B, 5'd0, 5'd5, 16'h28));
    emit(enc_i(6'h2B, 5'd0, 5'd6, 16'h2C));
    emit(enc_i(6'h2B, 5'd0, 5'd7, 16'h30));
    emit(enc_i(6'h2B, 5'd0, 5'd8, 16'h34));
    emit(enc_i(6'h2B, 5'd0, 5'd1, 16'h38));
    emit(enc_j(26'(pa)));
    exp_store(32'h20, 32'd2);
    exp_store(32'h24, 32'd1);
    exp_store(32'h28, 32'hFFFF_FFF8);
    exp_store(32'h2C, 32'd5);
    exp_store(32'h30, 32'hFFFF_FFFD);
    exp_store(32'h34, 32'd0);
    exp_store(32'h38, 32'd6);
    do_reset();
    run(22);
    end_test();

    // Memory: store, load back, store the loaded value
    clear_mem();
    emit(enc_i(6'h08, 5'd0, 5'd1, 16'd7));        // addi $1,$0,7
    emit(enc_i(6'h2B, 5'd0, 5'd1, 16'd8));        // sw   $1,8($0)
    emit(enc_i(6'h23, 5'd0, 5'd2, 16'd8));        // lw   $2,8($0)
    emit(enc_i(6'h2B, 5'd0, 5'd2, 16'd12));       // sw   $2,12($0)
    emit(enc_j(26'(pa)));
    exp_store(32'h8, 32'd7);
    exp_store(32'hC, 32'd7);
    for (int i = 0; i < 5; i++) pc_q.push_back(32'(i * 4));
    do_reset();
    run(7);
    end_test();

    // Control flow: taken beq, not-taken beq, jump
    clear_mem();
    emit(enc_i(6'h08, 5'd0, 5'd1, 16'd5));        // 0x00 addi $1,$0,5
    emit(32'h0);                                 // 0x04
    emit(32'h0);                                 // 0x08
    emit(32'h0);                                 // 0x0C
    emit(enc_i(6'h04, 5'd0, 5'd0, 16'd2));        // 0x10 beq $0,$0,+2
    emit(enc_i(6'h2B, 5'd0, 5'd1, 16'h70));       // 0x14 skipped
    emit(enc_i(6'h2B, 5'd0, 5'd1, 16'h74));       // 0x18 skipped
    emit(enc_i(6'h04, 5'd1, 5'd0, 16'd4));        // 0x1C beq $1,$0 (not taken)
    emit(enc_j(26'h40));                          // 0x20 j 0x100
    imem[64] = enc_i(6'h2B, 5'd0, 5'd1, 16'h30);  // 0x100 sw $1,0x30($0)
    imem[65] = enc_j(26'h41);                     // 0x104 j 0x104
    exp_store(32'h30, 32'd5);
    pc_q.push_back(32'h00); pc_q.push_back(32'h04);
    pc_q.push_back(32'h08); pc_q.push_back(32'h0C);
    pc_q.push_back(32'h10); pc_q.push_back(32'h1C);
    pc_q.push_back(32'h20); pc_q.push_back(32'h100);
    pc_q.push_back(32'h104); pc_q.push_back(32'h104);
    do_reset();
    run(10);
    end_test();

    // Register $0 stays zero
    clear_mem();
    emit(enc_i(6'h08, 5'd0, 5'd0, 16'd9));        // addi $0,$0,9
    emit(enc_r(5'd0, 5'd0, 5'd1, 6'h20));         // add  $1,$0,$0
    emit(enc_i(6'h2B, 5'd0, 5'd1, 16'h40));       // sw   $1,0x40($0)
    emit(enc_i(6'h2B, 5'd0, 5'd0, 16'h44));       // sw   $0,0x44($0)
    emit(enc_j(26'(pa)));
    exp_store(32'h40, 32'd0);
    exp_store(32'h44, 32'd0);
    do_reset();
    run(6);
    end_test();

    // Reset pulse during a store abandons it
    clear_mem();
    emit(enc_i(6'h08, 5'd0, 5'd1, 16'd3));        // 0x0 addi $1,$0,3
    emit(enc_i(6'h2B, 5'd0, 5'd1, 16'h50));       // 0x4 sw $1,0x50($0)
    emit(enc_j(26'(pa)));                        // 0x8 j 0x8
    do_reset();
    step();
    Z_R = 1'b1;
    #1;
    check_eq("mid_we", {31'b0, DM_WE}, 32'd0);
    check_eq("mid_pc_sw", IM_ADDR, 32'h4);
    @(posedge CLK);
    @(negedge CLK);
    Z_R = 1'b0;
    #1;
    check_eq("mid_rst_pc", IM_ADDR, 32'h0);
    check_eq("mid_no_write", dmem[20], 32'h0);
    @(negedge CLK);
    exp_store(32'h50, 32'd3);
    pc_q.push_back(32'h0); pc_q.push_back(32'h4); pc_q.push_back(32'h8);
    Z_R = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Z_R = 1'b0;
    run(4);
    end_test();

    // bne: taken only when the feature is compiled in
    clear_mem();
    emit(enc_i(6'h08, 5'd0, 5'd1, 16'd1));        // 0x0 addi $1,$0,1
    emit(enc_i(6'h05, 5'd1, 5'd0, 16'd1));        // 0x4 bne $1,$0,+1
    emit(enc_i(6'h2B, 5'd0, 5'd1, 16'h60));       // 0x8 sw $1,0x60($0)
    emit(enc_i(6'h2B, 5'd0, 5'd1, 16'h64));       // 0xC sw $1,0x64($0)
    emit(enc_j(26'(pa)));                        // 0x10
    pc_q.push_back(32'h0); pc_q.push_back(32'h4);
`ifdef MIPS_BNE_EN
    pc_q.push_back(32'hC);
`else
    pc_q.push_back(32'h8); pc_q.push_back(32'hC);
    exp_store(32'h60, 32'd1);
`endif
    pc_q.push_back(32'h10);
    exp_store(32'h64, 32'd1);
    do_reset();
    run(6);
    end_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
